mc_condlogic: RTL and testbench

Conditional-execution unit for the multicycle ARM controller. Holds the architectural NZCV flags register and evaluates the 4-bit condition field of the current instruction. Registers the pass/fail result so it aligns with the main FSM's later states. Gates the FSM's raw write strobes (PC, register file, memory) into the final datapath enables.

---
 rtl/arm_mc_pkg.sv | 28 ++
 rtl/cond_check.sv | 40 ++++
 rtl/mc_condlogic.sv | 52 +++++
 tb/tb_mc_condlogic.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared types and constants for the multicycle ARM controller
package arm_mc_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation against NZCV
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // NV falls through to the default so it never executes.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_t'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_condlogic.sv
// rtl/mc_condlogic.sv - NZCV flags, registered condition result and write-strobe gating
module mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q;

  cond_check u_cond_check (
    .cond_i    (Cond),
    .flags_i   (flags_q),
    .cond_ex_o (CondEx)
  );

  // N,Z and C,V halves update independently, both gated by this cycle's condition.
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] & CondEx) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[0] & CondEx) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q           <= 4'b0000;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= CondEx;
    end
  end

  assign PCWrite  = NextPC | (PCS & cond_ex_delayed_q);
  assign RegWrite = RegW & cond_ex_delayed_q;
  assign MemWrite = MemW & cond_ex_delayed_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_mc_condlogic.sv
// tb/tb_mc_condlogic.sv - self-checking bench for mc_condlogic
module tb_mc_condlogic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_flags;
  logic       m_cexd;

  mc_condlogic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondEx   (CondEx)
  );

  always #5 clk = ~clk;

  // Even codes test a base predicate, the following odd code is its inverse; AL/NV pair likewise.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic [7:0] base;
    {n, z, cf, v} = f;
    base = {1'b1, ~z & (n == v), n == v, cf & ~z, v, n, cf, z};
    return base[c[3:1]] ^ c[0];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".Flags"}, Flags, m_flags);
    check({tag, ".CondEx"}, {3'b0, CondEx}, {3'b0, ref_cond(Cond, m_flags)});
    check({tag, ".PCWrite"}, {3'b0, PCWrite}, {3'b0, NextPC | (PCS & m_cexd)});
    check({tag, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, RegW & m_cexd});
    check({tag, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, MemW & m_cexd});
  endtask

  // Advance the model with the inputs currently held, then cross one rising edge.
  task automatic tick();
    logic ce;
    ce = ref_cond(Cond, m_flags);
    if (reset) begin
      m_flags = 4'b0000;
      m_cexd  = 1'b0;
    end else begin
      if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
      m_cexd = ce;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; FlagW = 2'b00;
  endtask

  task automatic load_flags(input logic [3:0] f);
    idle_strobes();
    Cond = 4'b1110; ALUFlags = f; FlagW = 2'b11;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    m_flags = 4'b0000;
    m_cexd  = 1'b0;
    reset = 1; Cond = 4'b0000; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1; NextPC = 0; RegW = 1; MemW = 1;
    tick();
    tick();
    check("rst.Flags", Flags, 4'b0000);
    check("rst.RegWrite", {3'b0, RegWrite}, 4'd0);
    check("rst.MemWrite", {3'b0, MemWrite}, 4'd0);
    check("rst.PCWrite", {3'b0, PCWrite}, 4'd0);
    check("rst.CondEx", {3'b0, CondEx}, 4'd0);
    NextPC = 1;
    #1;
    check("rst.PCWrite_nextpc", {3'b0, PCWrite}, 4'd1);
    reset = 0;
    tick();

    // Condition sweep; FlagW held low so intervening edges leave Flags alone.
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      check("sweep.Flags", Flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        check($sformatf("sweep.c%0d.f%0d", c, f), {3'b0, CondEx}, {3'b0, ref_cond(4'(c), 4'(f))});
      end
      Cond = 4'b1110;
      tick();
    end

    // Split flag write
    load_flags(4'b0000);
    Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b10;
    tick();
    check("split.nz", Flags, 4'b1100);
    FlagW = 2'b01;
    tick();
    check("split.cv", Flags, 4'b1111);

    // Failed EQ blocks writes and flag update
    load_flags(4'b0000);
    Cond = 4'b0000;
    tick();
    RegW = 1; MemW = 1; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fail.RegWrite", {3'b0, RegWrite}, 4'd0);
      check("fail.MemWrite", {3'b0, MemWrite}, 4'd0);
      check("fail.PCWrite", {3'b0, PCWrite}, 4'd0);
      tick();
      check("fail.Flags", Flags, 4'b0000);
    end

    // Passed branch, then unconditional FETCH with NV
    load_flags(4'b0100);
    Cond = 4'b0000;
    tick();
    PCS = 1;
    #1;
    check("branch.PCWrite", {3'b0, PCWrite}, 4'd1);
    PCS = 0; Cond = 4'b1111; NextPC = 1;
    tick();
    check("fetch.PCWrite", {3'b0, PCWrite}, 4'd1);
    check("fetch.CondEx", {3'b0, CondEx}, 4'd0);

    // Randomized cycles against the model
    idle_strobes();
    for (int i = 0; i < 2000; i++) begin
      Cond     = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagW    = 2'($urandom);
      PCS      = 1'($urandom);
      NextPC   = 1'($urandom);
      RegW     = 1'($urandom);
      MemW     = 1'($urandom);
      #1;
      check_outputs($sformatf("rand%0d", i));
      tick();
    end

    // Asynchronous reset between edges
    load_flags(4'b1010);
    RegW = 1; MemW = 1;
    #1;
    check("arst.pre_RegWrite", {3'b0, RegWrite}, 4'd1);
    #1;
    reset = 1;
    #1;
    check("arst.RegWrite", {3'b0, RegWrite}, 4'd0);
    check("arst.MemWrite", {3'b0, MemWrite}, 4'd0);
    check("arst.Flags", Flags, 4'b0000);
    m_flags = 4'b0000;
    m_cexd  = 1'b0;
    tick();
    reset = 0;
    tick();
    check_outputs("arst.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
